// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache between the MEM stage and main memory.
// Load hits return data in the same cycle; misses refill a whole line one beat at a time.
`timescale 1ns/1ps
module dcache_controller #(
    parameter int unsigned NUM_LINES      = 16,
    parameter int unsigned WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        cache_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);
    localparam int unsigned IDX_W = $clog2(NUM_LINES);
    localparam int unsigned OFF_W = $clog2(WORDS_PER_LINE);
    localparam int unsigned TAG_W = 32 - 2 - OFF_W - IDX_W;
    localparam int unsigned WORDS = NUM_LINES * WORDS_PER_LINE;

    typedef enum logic [1:0] {IDLE, REFILL, WRITE, DONE} state_t;

    state_t             state;
    logic [OFF_W-1:0]   beat;
    logic [NUM_LINES-1:0] valid;
    logic [TAG_W-1:0]   tags [NUM_LINES];
    logic [31:0]        data [WORDS];

    logic [OFF_W-1:0]   offset;
    logic [IDX_W-1:0]   index;
    logic [TAG_W-1:0]   tag;
    logic               hit;
    logic [31:0]        word;
    logic               last_beat;
    logic               unused_addr_lsb;

    assign offset          = addr[2 +: OFF_W];
    assign index           = addr[2 + OFF_W +: IDX_W];
    assign tag             = addr[31 -: TAG_W];
    assign hit             = valid[index] && (tags[index] == tag);
    assign word            = data[{index, offset}];
    assign last_beat       = (beat == OFF_W'(WORDS_PER_LINE - 1));
    assign unused_addr_lsb = ^addr[1:0];

    // Control state, valid bits and saturating load counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            beat       <= '0;
            valid      <= '0;
            hit_count  <= 16'd0;
            miss_count <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (memwrite) begin
                        state <= WRITE;
                    end else if (memread) begin
                        if (hit) begin
                            if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
                        end else begin
                            if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
                            state <= REFILL;
                        end
                    end
                end
                REFILL: begin
                    if (mem_ready) begin
                        beat <= beat + OFF_W'(1);
                        if (last_beat) begin
                            beat         <= '0;
                            valid[index] <= 1'b1;
                            state        <= DONE;
                        end
                    end
                end
                WRITE: begin
                    if (mem_ready) state <= DONE;
                end
                DONE: state <= IDLE;
            endcase
        end
    end

    // Tag and data arrays carry no reset; a line only becomes usable once its valid bit is set
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == REFILL && mem_ready) begin
                data[{index, beat}] <= mem_rdata;
                if (last_beat) tags[index] <= tag;
            end
            if (state == WRITE && mem_ready && hit) begin
                data[{index, offset}] <= writedata;
            end
        end
    end

    // Pipeline and memory-side outputs; stall and hit data are combinational on the request
    always_comb begin
        readdata    = 32'd0;
        cache_stall = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = 32'd0;
        mem_wdata   = 32'd0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    cache_stall = memwrite || (memread && !hit);
                    if (memread && !memwrite && hit) readdata = word;
                end
                REFILL: begin
                    cache_stall = 1'b1;
                    mem_req     = 1'b1;
                    mem_addr    = {tag, index, beat, 2'b00};
                end
                WRITE: begin
                    cache_stall = 1'b1;
                    mem_req     = 1'b1;
                    mem_we      = 1'b1;
                    mem_addr    = {addr[31:2], 2'b00};
                    mem_wdata   = writedata;
                end
                DONE: begin
                    if (memread && hit) readdata = word;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller: a memory responder with programmable wait states,
// a reference cache/memory model and a queue of expected load data.
`timescale 1ns/1ps
module tb_dcache_controller;
    logic        clk = 1'b0;
    logic        reset;
    logic        memread, memwrite;
    logic [31:0] addr, writedata, readdata;
    logic        cache_stall, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ready = 1'b0;
    logic [15:0] hit_count, miss_count;

    dcache_controller #(.NUM_LINES(16), .WORDS_PER_LINE(4)) dut (
        .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
        .addr(addr), .writedata(writedata), .readdata(readdata),
        .cache_stall(cache_stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [31:0] mem_model [int unsigned];
    int          wait_cfg = 0;
    int          wcnt = 0;
    int          mem_writes = 0;
    logic [31:0] beat_addrs [$];
    logic [31:0] exp_q [$];

    logic        m_valid [16];
    logic [23:0] m_tag [16];
    int          m_hits = 0;
    int          m_miss = 0;

    task automatic check(input string tg, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tg, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input int unsigned wa);
        return mem_model.exists(wa) ? mem_model[wa] : 32'd0;
    endfunction

    // Main-memory responder: each beat completes after wait_cfg idle cycles
    always @(negedge clk) begin
        if (mem_req) begin
            if (wcnt == wait_cfg) begin
                mem_ready = 1'b1;
                mem_rdata = mem_rd(32'(mem_addr[31:2]));
                beat_addrs.push_back(mem_addr);
                if (mem_we) begin
                    mem_model[32'(mem_addr[31:2])] = mem_wdata;
                    mem_writes++;
                end
                wcnt = 0;
            end else begin
                mem_ready = 1'b0;
                wcnt++;
            end
        end else begin
            mem_ready = 1'b0;
            mem_rdata = 32'd0;
            wcnt = 0;
        end
    end

    task automatic clear_model();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        m_hits = 0;
        m_miss = 0;
    endtask

    task automatic check_counters(input string tg);
        check($sformatf("%s hit_count", tg), 32'(hit_count), 32'(m_hits));
        check($sformatf("%s miss_count", tg), 32'(miss_count), 32'(m_miss));
    endtask

    // Called just after a rising edge; returns just after the edge that retires the load
    task automatic do_load(input logic [31:0] a, input string tg);
        logic [3:0] idx;
        logic       exp_hit;
        int         stalls;
        idx     = a[7:4];
        exp_hit = m_valid[idx] && (m_tag[idx] == a[31:8]);
        exp_q.push_back(mem_rd(32'(a[31:2])));
        beat_addrs.delete();
        memread = 1'b1;
        addr    = a;
        @(negedge clk);
        stalls = 0;
        while (cache_stall && stalls < 100) begin
            stalls++;
            @(negedge clk);
        end
        check($sformatf("%s readdata", tg), readdata, exp_q.pop_front());
        check($sformatf("%s mem_req", tg), 32'(mem_req), 32'd0);
        if (exp_hit) begin
            check($sformatf("%s hit stall", tg), 32'(stalls), 32'd0);
            if (m_hits < 65535) m_hits++;
        end else begin
            check($sformatf("%s miss stall", tg), 32'(stalls), 32'(1 + 4 * (wait_cfg + 1)));
            check($sformatf("%s beats", tg), 32'(beat_addrs.size()), 32'd4);
            for (int i = 0; i < 4 && i < beat_addrs.size(); i++)
                check($sformatf("%s beat%0d addr", tg, i), beat_addrs[i], {a[31:4], 4'(i * 4)});
            m_miss++;
            m_valid[idx] = 1'b1;
            m_tag[idx]   = a[31:8];
        end
        @(posedge clk); #1;
        memread = 1'b0;
        check_counters(tg);
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic also_read,
                            input string tg);
        logic [3:0] idx;
        logic       exp_hit;
        int         stalls, we_cycles, w0;
        idx     = a[7:4];
        exp_hit = m_valid[idx] && (m_tag[idx] == a[31:8]);
        w0      = mem_writes;
        memwrite  = 1'b1;
        memread   = also_read;
        addr      = a;
        writedata = d;
        @(negedge clk);
        stalls = 0;
        we_cycles = 0;
        while (cache_stall && stalls < 100) begin
            stalls++;
            if (mem_req && mem_we && mem_addr == {a[31:2], 2'b00} && mem_wdata == d) we_cycles++;
            @(negedge clk);
        end
        check($sformatf("%s stall", tg), 32'(stalls), 32'(2 + wait_cfg));
        check($sformatf("%s write cycles", tg), 32'(we_cycles), 32'(1 + wait_cfg));
        check($sformatf("%s readdata", tg), readdata, (also_read && exp_hit) ? d : 32'd0);
        @(posedge clk); #1;
        memwrite = 1'b0;
        memread  = 1'b0;
        check($sformatf("%s mem writes", tg), 32'(mem_writes), 32'(w0 + 1));
        check_counters(tg);
    endtask

    initial begin
        reset = 1'b1; memread = 1'b0; memwrite = 1'b0; addr = 32'd0; writedata = 32'd0;
        clear_model();
        for (int i = 0; i < 4; i++) begin
            mem_model[32'(16 + i)] = 32'h11 * 32'(i + 1);
            mem_model[32'(32 + i)] = 32'hA0 + 32'(i);
        end
        repeat (2) @(posedge clk);
        memread = 1'b1; memwrite = 1'b1; addr = 32'h40;
        @(negedge clk);
        check("rst stall", 32'(cache_stall), 32'd0);
        check("rst mem_req", 32'(mem_req), 32'd0);
        check("rst mem_we", 32'(mem_we), 32'd0);
        check("rst readdata", readdata, 32'd0);
        @(posedge clk); #1;
        memread = 1'b0; memwrite = 1'b0;
        reset = 1'b0;
        check_counters("rst");

        wait_cfg = 0;
        do_load(32'h40, "cold ld 40");
        do_load(32'h48, "hit ld 48");
        wait_cfg = 3;
        do_store(32'h44, 32'hDEADBEEF, 1'b0, "st hit 44");
        wait_cfg = 0;
        do_load(32'h44, "ld 44 after st");
        do_store(32'h1000, 32'h0000CAFE, 1'b0, "st miss 1000");
        do_load(32'h1000, "ld 1000");
        do_store(32'h40, 32'h12345678, 1'b1, "rd+wr 40");
        wait_cfg = 1;
        do_load(32'h104C, "evict ld 104c");
        wait_cfg = 0;
        do_load(32'h40, "reload 40");

        // Reset in the middle of a refill, after beat 1 completes
        memread = 1'b1; addr = 32'h80;
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b1; memread = 1'b0;
        @(negedge clk);
        check("mid-rst mem_req", 32'(mem_req), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        clear_model();
        @(negedge clk);
        check("post-rst mem_req", 32'(mem_req), 32'd0);
        check("post-rst stall", 32'(cache_stall), 32'd0);
        @(posedge clk); #1;
        check_counters("post-rst");
        do_load(32'h80, "ld 80 after rst");

        // Hold a resident load long enough to saturate the hit counter
        memread = 1'b1; addr = 32'h88;
        @(negedge clk);
        check("sat readdata", readdata, mem_rd(32'h22));
        check("sat stall", 32'(cache_stall), 32'd0);
        repeat (65540) @(posedge clk);
        #1;
        memread = 1'b0;
        check("sat hit_count", 32'(hit_count), 32'h0000FFFF);
        check("sat miss_count", 32'(miss_count), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/dcache_controller.md
DCACHE_CONTROLLER -- requirements
Module: dcache_controller

Interface
REQ-001 Parameter NUM_LINES, default 16, number of direct-mapped lines (power of two, index width log2(NUM_LINES)).
REQ-002 Parameter WORDS_PER_LINE, default 4, 32-bit words per line (power of two, beat width log2(WORDS_PER_LINE)).
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 memread  in  1  pipeline MEM-stage load request.
REQ-006 memwrite  in  1  pipeline MEM-stage store request.
REQ-007 addr  in  32  byte address (pipeline ULAout_mem); bits [1:0] ignored.
REQ-008 writedata  in  32  store data (pipeline writedata_mem).
REQ-009 readdata  out  32  load data returned to pipeline.
REQ-010 cache_stall  out  1  freeze EX/MEM and MEM/WB registers while high.
REQ-011 mem_req  out  1  main-memory request valid.
REQ-012 mem_we  out  1  main-memory write enable (qualifies mem_req).
REQ-013 mem_addr  out  32  main-memory word address, bits [1:0] = 0.
REQ-014 mem_wdata  out  32  main-memory write data.
REQ-015 mem_rdata  in  32  main-memory read data, valid when mem_ready.
REQ-016 mem_ready  in  1  main-memory completes current beat this cycle.
REQ-017 hit_count, miss_count  out  16 each  saturating load hit/miss counters.

Function
REQ-018 Address split: offset=addr[2+:beat width], index=next log2(NUM_LINES) bits, tag=remaining upper bits; per line one valid bit, one tag, WORDS_PER_LINE data words.
REQ-019 Hit = valid[index] && tag match; policy write-through, no-write-allocate, load-allocate.
REQ-020 FSM states IDLE, REFILL, WRITE, DONE.
REQ-021 IDLE: memwrite has priority over memread; memwrite -> WRITE; memread && miss -> REFILL; memread && hit -> stay IDLE; else stay IDLE.
REQ-022 Load hit in IDLE: readdata = stored word combinationally, cache_stall=0, zero-latency, hit_count+1.
REQ-023 Load miss or any store in IDLE: cache_stall=1 combinationally in that same cycle; load miss increments miss_count.
REQ-024 REFILL: mem_req=1, mem_we=0, mem_addr={tag,index,beat,2'b00}; beat counter starts at 0; on mem_ready write mem_rdata into word[beat], beat+1; cache_stall=1.
REQ-025 REFILL last beat (beat=WORDS_PER_LINE-1 with mem_ready): set valid[index], store tag, beat->0, go DONE.
REQ-026 mem_ready low holds state, beat and all mem_* outputs stable.
REQ-027 WRITE: mem_req=1, mem_we=1, mem_addr={addr[31:2],2'b00}, mem_wdata=writedata, cache_stall=1; on mem_ready: if hit update word[offset] only, go DONE.
REQ-028 DONE: cache_stall=0, mem_req=0, readdata = line word (valid since line now resident); unconditionally -> IDLE next cycle (inputs still held must not retrigger).
REQ-029 readdata = 0 whenever not (memread && hit); mem_we, mem_wdata = 0 when mem_req=0; mem_addr = 0 in IDLE/DONE.
REQ-030 Counters saturate at 16'hFFFF; stores not counted; a load counts exactly once (miss at IDLE entry to REFILL, no hit counted in DONE).
REQ-031 Store to a missing line never changes any valid bit, tag or data.

Reset
REQ-032 reset=1 at a rising edge: state->IDLE, beat->0, all valid bits->0, counters->0; data/tag arrays need no reset.
REQ-033 During and after reset: cache_stall=0, mem_req=0, mem_we=0, readdata=0.
REQ-034 Reset during REFILL or WRITE abandons the transaction; mem_req drops the following cycle; partially filled line stays invalid.

Verification
REQ-035 Cold load addr=0x0000_0040, memory returns 0x11,0x22,0x33,0x44 with mem_ready every cycle -> cache_stall high 5 cycles (IDLE+4 beats), mem_addr 0x40,0x44,0x48,0x4C, DONE readdata=0x11, miss_count=1.
REQ-036 Then load 0x0000_0048 -> same-cycle readdata=0x33, cache_stall=0, mem_req=0, hit_count=1.
REQ-037 Store 0xDEADBEEF to 0x0000_0044 (hit), mem_ready after 3 wait cycles -> mem_req/mem_we held 4 cycles at 0x44, next load 0x44 hits returning 0xDEADBEEF.
REQ-038 Store 0xCAFE to 0x0000_1000 (miss) -> one memory write, subsequent load 0x1000 misses and refills (miss_count increments).
REQ-039 memread and memwrite both high, addr 0x40 -> WRITE path taken, no refill, counters unchanged.
REQ-040 reset asserted after beat 1 of a refill -> mem_req=0 next cycle, reload of same address misses and refills all 4 beats; 65536+ load hits leave hit_count=16'hFFFF.
